// File: rtl/debug_regfile.sv
// debug_regfile: Wishbone classic slave exposing an ID word, a free-running
// cycle counter, sticky event flags with interrupt enables, scratch registers
// and read-only status words inside a 2^ADR_W byte window.
module debug_regfile #(
    parameter logic [31:0] BASE_ADR = 32'h3000_0000,
    parameter int          ADR_W    = 8,
    parameter int          NUM_RW   = 4,
    parameter int          NUM_RO   = 2,
    parameter int          NUM_EVT  = 8,
    parameter logic [31:0] ID_VAL   = 32'hDB60_0002
) (
    input  logic                   wb_clk_i,
    input  logic                   wb_rst_i,
    input  logic                   wbs_cyc_i,
    input  logic                   wbs_stb_i,
    input  logic                   wbs_we_i,
    input  logic [3:0]             wbs_sel_i,
    input  logic [31:0]            wbs_dat_i,
    input  logic [31:0]            wbs_adr_i,
    output logic                   wbs_ack_o,
    output logic [31:0]            wbs_dat_o,
    input  logic [NUM_EVT-1:0]     evt_i,
    input  logic [NUM_RO*32-1:0]   sts_i,
    output logic [NUM_RW*32-1:0]   dbg_reg_o,
    output logic                   irq_o
);

    localparam int          IDX_W   = ADR_W - 2;
    localparam logic [31:0] W_ID    = 32'd0;
    localparam logic [31:0] W_CYCLE = 32'd1;
    localparam logic [31:0] W_EVT   = 32'd2;
    localparam logic [31:0] W_IRQEN = 32'd3;
    localparam logic [31:0] W_SCR   = 32'd4;
    localparam logic [31:0] W_STS   = 32'(4 + NUM_RW);

    logic                  ack_q, ack_d;
    logic [31:0]           dat_q, dat_d;
    logic                  irq_q, irq_d;
    logic [31:0]           cycle_q, cycle_d;
    logic [NUM_EVT-1:0]    evt_q, evt_d;
    logic [NUM_EVT-1:0]    irq_en_q, irq_en_d;
    logic [NUM_RW*32-1:0]  scratch_q, scratch_d;

    logic                  hit_s;
    logic                  accept_s;
    logic                  wr_s;
    logic [31:0]           word_s;
    logic [31:0]           byte_mask_s;
    logic [31:0]           rd_val_s;
    logic [NUM_EVT-1:0]    evt_clr_s;
    logic                  unused_s;

    // Address bits [1:0] do not take part in decoding.
    assign unused_s = ^wbs_adr_i[1:0];

    assign hit_s    = (wbs_adr_i[31:ADR_W] == BASE_ADR[31:ADR_W]);
    assign accept_s = wbs_cyc_i & wbs_stb_i & hit_s & ~ack_q;
    assign wr_s     = accept_s & wbs_we_i;

    // Decode word index (zero-extended) and expand byte selects to a bit mask.
    always_comb begin
        word_s = 32'd0;
        word_s[IDX_W-1:0] = wbs_adr_i[ADR_W-1:2];
        byte_mask_s = {{8{wbs_sel_i[3]}}, {8{wbs_sel_i[2]}},
                       {8{wbs_sel_i[1]}}, {8{wbs_sel_i[0]}}};
    end

    // Read mux; CYCLE reads as the count committed at the accept edge, so the
    // cycle right after a clear or reset reads 1.
    always_comb begin
        rd_val_s = 32'd0;
        case (word_s)
            W_ID:    rd_val_s = ID_VAL;
            W_CYCLE: rd_val_s = cycle_q + 32'd1;
            W_EVT:   rd_val_s = 32'(evt_q);
            W_IRQEN: rd_val_s = 32'(irq_en_q);
            default: begin
                for (int r = 0; r < NUM_RW; r++) begin
                    rd_val_s = rd_val_s | ((word_s == W_SCR + 32'(r)) ?
                                           scratch_q[r*32 +: 32] : 32'd0);
                end
                for (int k = 0; k < NUM_RO; k++) begin
                    rd_val_s = rd_val_s | ((word_s == W_STS + 32'(k)) ?
                                           sts_i[k*32 +: 32] : 32'd0);
                end
            end
        endcase
    end

    // Next-state for bus response, counter, events, enables and scratch words.
    always_comb begin
        ack_d   = accept_s;
        dat_d   = (accept_s & ~wbs_we_i) ? rd_val_s : 32'd0;
        cycle_d = (wr_s && (word_s == W_CYCLE)) ? 32'd0 : cycle_q + 32'd1;
        irq_d   = |(evt_q & irq_en_q);
        for (int k = 0; k < NUM_EVT; k++) begin
            evt_clr_s[k] = wr_s && (word_s == W_EVT) && wbs_dat_i[k] && byte_mask_s[k];
            irq_en_d[k]  = (wr_s && (word_s == W_IRQEN) && byte_mask_s[k]) ?
                           wbs_dat_i[k] : irq_en_q[k];
        end
        // A new event in the same cycle as its clear keeps the flag set.
        evt_d = (evt_q & ~evt_clr_s) | evt_i;
        for (int r = 0; r < NUM_RW; r++) begin
            scratch_d[r*32 +: 32] = (wr_s && (word_s == W_SCR + 32'(r))) ?
                ((scratch_q[r*32 +: 32] & ~byte_mask_s) | (wbs_dat_i & byte_mask_s)) :
                scratch_q[r*32 +: 32];
        end
    end

    // State registers; reset discards any transaction accepted in that cycle.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            ack_q     <= 1'b0;
            dat_q     <= 32'd0;
            irq_q     <= 1'b0;
            cycle_q   <= 32'd0;
            evt_q     <= '0;
            irq_en_q  <= '0;
            scratch_q <= '0;
        end else begin
            ack_q     <= ack_d;
            dat_q     <= dat_d;
            irq_q     <= irq_d;
            cycle_q   <= cycle_d;
            evt_q     <= evt_d;
            irq_en_q  <= irq_en_d;
            scratch_q <= scratch_d;
        end
    end

    assign wbs_ack_o = ack_q;
    assign wbs_dat_o = dat_q;
    assign irq_o     = irq_q;
    assign dbg_reg_o = scratch_q;

endmodule

// File: tb/tb_debug_regfile.sv
// Self-checking bench for debug_regfile with randomized traffic against a
// behavioural model of the register map.
module tb_debug_regfile;

    localparam logic [31:0] BASE = 32'h3000_0000;
    localparam logic [31:0] ID   = 32'hDB60_0002;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         cyc = 1'b0, stb = 1'b0, we = 1'b0;
    logic [3:0]   sel = 4'd0;
    logic [31:0]  dat_i = 32'd0, adr = 32'd0;
    logic         ack;
    logic [31:0]  dat_o;
    logic [7:0]   evt = 8'd0;
    logic [63:0]  sts = 64'd0;
    logic [127:0] dbg;
    logic         irq;

    int checks = 0;
    int errors = 0;
    int edge_cnt = 0;
    int acc_edge = 0;
    int clr_edge = 0;

    logic [31:0] m_scr [4];
    logic [7:0]  m_evt, m_en;

    debug_regfile dut (
        .wb_clk_i(clk), .wb_rst_i(rst),
        .wbs_cyc_i(cyc), .wbs_stb_i(stb), .wbs_we_i(we),
        .wbs_sel_i(sel), .wbs_dat_i(dat_i), .wbs_adr_i(adr),
        .wbs_ack_o(ack), .wbs_dat_o(dat_o),
        .evt_i(evt), .sts_i(sts), .dbg_reg_o(dbg), .irq_o(irq)
    );

    always #5 clk = ~clk;
    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    function automatic logic [31:0] bmask(input logic [3:0] s);
        return {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
    endfunction

    function automatic logic [127:0] scr_pack();
        return {m_scr[3], m_scr[2], m_scr[1], m_scr[0]};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 4; i++) m_scr[i] = 32'd0;
        m_evt = 8'd0;
        m_en  = 8'd0;
    endtask

    // One single-beat transfer; stb drops right after the accept edge.
    task automatic xfer(input logic w, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] s, output logic [31:0] rd, output logic ak);
        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; we = w; adr = a; dat_i = d; sel = s;
        @(posedge clk);
        #1 acc_edge = edge_cnt;
        @(negedge clk);
        ak = ack; rd = dat_o;
        cyc = 1'b0; stb = 1'b0; we = 1'b0; sel = 4'd0; dat_i = 32'd0;
    endtask

    task automatic test_reset();
        logic [31:0] rd;
        logic        ak;
        model_reset();
        rst = 1'b1; evt = 8'hFF;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({ack, dat_o, irq, dbg} !== {1'b0, 32'd0, 1'b0, 128'd0}) begin
            errors++; $display("FAIL reset_outputs got ack=%b dat=%h irq=%b dbg=%h want all 0", ack, dat_o, irq, dbg);
        end
        // Read CYCLE in the very first cycle after release.
        rst = 1'b0; evt = 8'd0; cyc = 1'b1; stb = 1'b1; adr = BASE + 32'h4;
        @(posedge clk);
        #1 clr_edge = edge_cnt - 1;
        @(negedge clk);
        checks++;
        if (ack !== 1'b1 || dat_o !== 32'd1) begin
            errors++; $display("FAIL cycle_after_reset got ack=%b dat=%h want 1/00000001", ack, dat_o);
        end
        cyc = 1'b0; stb = 1'b0;
        xfer(1'b0, BASE + 32'h8, 32'd0, 4'hF, rd, ak);
        checks++;
        if (rd !== 32'd0) begin
            errors++; $display("FAIL evt_ignored_in_reset got %h want 0", rd);
        end
    endtask

    task automatic test_id();
        logic [31:0] rd;
        logic        ak;
        xfer(1'b0, BASE, 32'd0, 4'hF, rd, ak);
        checks++;
        if (ak !== 1'b1 || rd !== ID) begin
            errors++; $display("FAIL id_read got ack=%b dat=%h want 1/%h", ak, rd, ID);
        end
        @(negedge clk);
        checks++;
        if (ack !== 1'b0 || dat_o !== 32'd0) begin
            errors++; $display("FAIL id_after_ack got ack=%b dat=%h want 0/0", ack, dat_o);
        end
        xfer(1'b1, BASE, 32'hFFFF_FFFF, 4'hF, rd, ak);
        xfer(1'b0, BASE + 32'h3, 32'd0, 4'hF, rd, ak);
        checks++;
        if (rd !== ID) begin
            errors++; $display("FAIL id_write_ignored got %h want %h", rd, ID);
        end
    endtask

    task automatic test_scratch();
        logic [31:0] rd, d;
        logic        ak;
        logic [3:0]  s;
        int          i;
        xfer(1'b1, BASE + 32'h10, 32'hAABB_CCDD, 4'b0101, rd, ak);
        m_scr[0] = 32'h00BB_00DD;
        checks++;
        if (ak !== 1'b1 || rd !== 32'd0 || dbg[31:0] !== 32'h00BB_00DD) begin
            errors++; $display("FAIL scratch_sel got ack=%b dat=%h dbg0=%h want 1/0/00bb00dd", ak, rd, dbg[31:0]);
        end
        xfer(1'b0, BASE + 32'h10, 32'd0, 4'hF, rd, ak);
        checks++;
        if (rd !== 32'h00BB_00DD) begin
            errors++; $display("FAIL scratch_readback got %h want 00bb00dd", rd);
        end
        for (int n = 0; n < 12; n++) begin
            i = $urandom_range(3, 0);
            d = $urandom;
            s = 4'($urandom_range(15, 0));
            xfer(1'b1, BASE + 32'h10 + 32'(4 * i), d, s, rd, ak);
            m_scr[i] = (m_scr[i] & ~bmask(s)) | (d & bmask(s));
            checks++;
            if (ak !== 1'b1 || rd !== 32'd0 || dbg !== scr_pack()) begin
                errors++; $display("FAIL scratch_wr got ack=%b dat=%h dbg=%h want 1/0/%h", ak, rd, dbg, scr_pack());
            end
            i = $urandom_range(3, 0);
            xfer(1'b0, BASE + 32'h10 + 32'(4 * i), 32'd0, 4'h0, rd, ak);
            checks++;
            if (ak !== 1'b1 || rd !== m_scr[i]) begin
                errors++; $display("FAIL scratch_rd[%0d] got ack=%b dat=%h want 1/%h", i, ak, rd, m_scr[i]);
            end
        end
    endtask

    task automatic test_status();
        logic [31:0] rd;
        logic        ak;
        for (int n = 0; n < 4; n++) begin
            @(negedge clk);
            sts = {$urandom, $urandom};
            for (int k = 0; k < 2; k++) begin
                xfer(1'b1, BASE + 32'h20 + 32'(4 * k), 32'hFFFF_FFFF, 4'hF, rd, ak);
                xfer(1'b0, BASE + 32'h20 + 32'(4 * k), 32'd0, 4'hF, rd, ak);
                checks++;
                if (rd !== sts[k*32 +: 32]) begin
                    errors++; $display("FAIL status_rd[%0d] got %h want %h", k, rd, sts[k*32 +: 32]);
                end
            end
        end
    endtask

    task automatic test_cycle();
        logic [31:0] rd;
        logic        ak;
        int          gap;
        xfer(1'b1, BASE + 32'h4, 32'h1234_5678, 4'h0, rd, ak);
        clr_edge = acc_edge;
        repeat (3) @(negedge clk);
        xfer(1'b0, BASE + 32'h4, 32'd0, 4'hF, rd, ak);
        checks++;
        if (rd !== 32'd5) begin
            errors++; $display("FAIL cycle_distance got %0d want 5", rd);
        end
        for (int n = 0; n < 5; n++) begin
            gap = $urandom_range(7, 0);
            repeat (gap) @(negedge clk);
            xfer(1'b0, BASE + 32'h4, 32'd0, 4'hF, rd, ak);
            checks++;
            if (rd !== 32'(acc_edge - clr_edge)) begin
                errors++; $display("FAIL cycle_count got %0d want %0d", rd, acc_edge - clr_edge);
            end
        end
        force dut.cycle_q = 32'hFFFF_FFFF;
        xfer(1'b0, BASE + 32'h4, 32'd0, 4'hF, rd, ak);
        release dut.cycle_q;
        checks++;
        if (rd !== 32'd0) begin
            errors++; $display("FAIL cycle_wrap got %h want 0", rd);
        end
        xfer(1'b1, BASE + 32'h4, 32'd0, 4'hF, rd, ak);
        clr_edge = acc_edge;
    endtask

    task automatic test_evt_irq();
        logic [31:0] rd, d;
        logic        ak;
        logic [3:0]  s;
        logic [7:0]  p;
        @(negedge clk); evt = 8'h08;
        @(negedge clk); evt = 8'h00;
        m_evt = m_evt | 8'h08;
        xfer(1'b1, BASE + 32'hC, 32'h0000_0008, 4'hF, rd, ak);
        m_en = 8'h08;
        xfer(1'b0, BASE + 32'h8, 32'd0, 4'hF, rd, ak);
        checks++;
        if (rd !== 32'h08 || irq !== 1'b1) begin
            errors++; $display("FAIL evt_set got evt=%h irq=%b want 08/1", rd, irq);
        end
        @(negedge clk); evt = 8'h08;
        xfer(1'b1, BASE + 32'h8, 32'h0000_0008, 4'hF, rd, ak);
        evt = 8'h00;
        xfer(1'b0, BASE + 32'h8, 32'd0, 4'hF, rd, ak);
        checks++;
        if (rd !== 32'h08) begin
            errors++; $display("FAIL evt_set_wins got %h want 08", rd);
        end
        xfer(1'b1, BASE + 32'h8, 32'h0000_0008, 4'hF, rd, ak);
        m_evt = 8'h00;
        checks++;
        if (irq !== 1'b1) begin
            errors++; $display("FAIL irq_lag got %b want 1", irq);
        end
        @(negedge clk);
        checks++;
        if (irq !== 1'b0) begin
            errors++; $display("FAIL irq_clear got %b want 0", irq);
        end
        xfer(1'b1, BASE + 32'hC, 32'hFFFF_FFFF, 4'hF, rd, ak);
        m_en = 8'hFF;
        xfer(1'b0, BASE + 32'hC, 32'd0, 4'hF, rd, ak);
        checks++;
        if (rd !== 32'h0000_00FF) begin
            errors++; $display("FAIL irq_en_width got %h want 000000ff", rd);
        end
        for (int n = 0; n < 10; n++) begin
            p = 8'($urandom);
            @(negedge clk); evt = p;
            @(negedge clk); evt = 8'h00;
            m_evt = m_evt | p;
            d = $urandom; s = 4'($urandom_range(15, 0));
            xfer(1'b1, BASE + 32'h8, d, s, rd, ak);
            m_evt = m_evt & ~(d[7:0] & bmask(s) & 8'hFF);
            d = $urandom; s = 4'($urandom_range(15, 0));
            xfer(1'b1, BASE + 32'hC, d, s, rd, ak);
            m_en = (m_en & ~(bmask(s) & 8'hFF)) | (d[7:0] & bmask(s) & 8'hFF);
            xfer(1'b0, BASE + 32'h8, 32'd0, 4'hF, rd, ak);
            checks++;
            if (rd !== {24'd0, m_evt} || irq !== |(m_evt & m_en)) begin
                errors++; $display("FAIL evt_rand got evt=%h irq=%b want %h/%b", rd, irq, m_evt, |(m_evt & m_en));
            end
            xfer(1'b0, BASE + 32'hC, 32'd0, 4'hF, rd, ak);
            checks++;
            if (rd !== {24'd0, m_en}) begin
                errors++; $display("FAIL irq_en_rand got %h want %h", rd, m_en);
            end
        end
    endtask

    task automatic test_unmapped();
        logic [31:0] rd;
        logic        ak;
        xfer(1'b0, BASE + 32'h100, 32'd0, 4'hF, rd, ak);
        checks++;
        if (ak !== 1'b0 || rd !== 32'd0) begin
            errors++; $display("FAIL nonhit_read got ack=%b dat=%h want 0/0", ak, rd);
        end
        xfer(1'b1, BASE + 32'h110, 32'hFFFF_FFFF, 4'hF, rd, ak);
        checks++;
        if (ak !== 1'b0 || dbg !== scr_pack()) begin
            errors++; $display("FAIL nonhit_write got ack=%b dbg=%h want 0/%h", ak, dbg, scr_pack());
        end
        xfer(1'b0, BASE + 32'h3C, 32'd0, 4'hF, rd, ak);
        checks++;
        if (ak !== 1'b1 || rd !== 32'd0) begin
            errors++; $display("FAIL unmapped_read got ack=%b dat=%h want 1/0", ak, rd);
        end
        xfer(1'b1, BASE + 32'h3C, 32'hFFFF_FFFF, 4'hF, rd, ak);
        checks++;
        if (ak !== 1'b1 || dbg !== scr_pack()) begin
            errors++; $display("FAIL unmapped_write got ack=%b dbg=%h want 1/%h", ak, dbg, scr_pack());
        end
        xfer(1'b0, BASE + 32'hC, 32'd0, 4'hF, rd, ak);
        checks++;
        if (rd !== {24'd0, m_en}) begin
            errors++; $display("FAIL unmapped_side_effect got %h want %h", rd, m_en);
        end
    endtask

    task automatic test_back_to_back();
        logic exp_ack;
        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = BASE; sel = 4'hF;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            exp_ack = (i % 2 == 0);
            checks++;
            if (ack !== exp_ack || dat_o !== (exp_ack ? ID : 32'd0)) begin
                errors++; $display("FAIL b2b[%0d] got ack=%b dat=%h want %b", i, ack, dat_o, exp_ack);
            end
        end
        cyc = 1'b0; stb = 1'b0;
    endtask

    task automatic test_reset_collision();
        logic [31:0] rd;
        logic        ak;
        xfer(1'b1, BASE + 32'h8, 32'hFFFF_FFFF, 4'hF, rd, ak);
        @(negedge clk); evt = 8'h01;
        xfer(1'b1, BASE + 32'hC, 32'h0000_0001, 4'hF, rd, ak);
        evt = 8'h00;
        @(negedge clk);
        rst = 1'b1; evt = 8'hFF;
        cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = BASE + 32'h14; dat_i = 32'hFFFF_FFFF; sel = 4'hF;
        @(negedge clk);
        rst = 1'b0; evt = 8'h00; cyc = 1'b0; stb = 1'b0; we = 1'b0;
        model_reset();
        checks++;
        if ({ack, dat_o, irq, dbg} !== {1'b0, 32'd0, 1'b0, 128'd0}) begin
            errors++; $display("FAIL reset_collision got ack=%b dat=%h irq=%b dbg=%h want all 0", ack, dat_o, irq, dbg);
        end
        @(negedge clk);
        checks++;
        if (ack !== 1'b0) begin
            errors++; $display("FAIL reset_no_late_ack got %b want 0", ack);
        end
        xfer(1'b0, BASE + 32'h8, 32'd0, 4'hF, rd, ak);
        checks++;
        if (rd !== 32'd0) begin
            errors++; $display("FAIL reset_evt got %h want 0", rd);
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_id();
        test_scratch();
        test_status();
        test_cycle();
        test_evt_irq();
        test_unmapped();
        test_back_to_back();
        test_reset_collision();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/debug_regfile.md
DEBUG_REGFILE -- requirements
Module: debug_regfile

Interface
REQ-001 SHALL provide parameter BASE_ADR, default 32'h3000_0000: byte base address of the register window.
REQ-002 SHALL provide parameter ADR_W, default 8: window size is 2^ADR_W bytes.
REQ-003 SHALL provide parameter NUM_RW, default 4, range 1..8: number of 32-bit scratch registers.
REQ-004 SHALL provide parameter NUM_RO, default 2, range 1..8: number of 32-bit read-only status inputs.
REQ-005 SHALL provide parameter NUM_EVT, default 8, range 1..32: number of sticky event bits.
REQ-006 SHALL provide parameter ID_VAL, default 32'hDB60_0002: value returned by the ID register.
REQ-007 Port wb_clk_i, input, 1: the single clock; all logic is rising-edge.
REQ-008 Port wb_rst_i, input, 1: reset, synchronous and active-high.
REQ-009 Ports wbs_cyc_i, wbs_stb_i, wbs_we_i: inputs, 1 each: Wishbone classic slave controls.
REQ-010 Ports wbs_sel_i (4), wbs_dat_i (32), wbs_adr_i (32): inputs: byte selects, write data, byte address.
REQ-011 Ports wbs_ack_o (1) and wbs_dat_o (32): registered outputs: acknowledge and read data.
REQ-012 Port evt_i, input, NUM_EVT: level event sources.
REQ-013 Port sts_i, input, NUM_RO*32: status words; word k is sts_i[32k+31:32k].
REQ-014 Port dbg_reg_o, output, NUM_RW*32: scratch register contents, packed the same way.
REQ-015 Port irq_o, output, 1: registered interrupt request.

Function
REQ-016 Hit: wbs_adr_i[31:ADR_W]==BASE_ADR[31:ADR_W]; the word index is wbs_adr_i[ADR_W-1:2], and bits [1:0] are ignored.
REQ-017 The word map SHALL be: 0 ID (RO); 1 CYCLE (RO, clear on write); 2 EVT (W1C); 3 IRQ_EN (RW, NUM_EVT bits); 4..4+NUM_RW-1 scratch (RW); 4+NUM_RW..4+NUM_RW+NUM_RO-1 status (RO); all other indices unmapped.
REQ-018 Accept: a transaction is accepted in a cycle with cyc&stb&hit&!wbs_ack_o.
REQ-019 Ack: wbs_ack_o SHALL be high for exactly the one cycle after acceptance; the latency is 1.
REQ-020 If stb stays high after an ack, ack SHALL be low for one cycle, then re-asserted; the maximum rate is one ack every 2 cycles.
REQ-021 A non-hit address SHALL never be acked, and no state SHALL change.
REQ-022 wbs_dat_o SHALL carry the read value only in the ack cycle of a read; it SHALL be 0 at all other times, including write acks.
REQ-023 Read data SHALL be the register value sampled in the accept cycle.
REQ-024 Unmapped or RO words: reads return 0 (for unmapped) or the RO value; writes are acked and ignored.
REQ-025 Scratch and IRQ_EN writes SHALL update only bytes with wbs_sel_i[b]=1; IRQ_EN bits at or above NUM_EVT read 0.
REQ-026 CYCLE SHALL increment by 1 every cycle and wrap from 32'hFFFF_FFFF to 0.
REQ-027 Any accepted write to CYCLE, regardless of sel, SHALL load 0 in that edge; the next cycle reads 1.
REQ-028 EVT[k] SHALL set on any cycle with evt_i[k]=1.
REQ-029 An accepted EVT write SHALL clear EVT[k] where wbs_dat_i[k]=1 and the byte is selected.
REQ-030 If set and clear of the same bit occur in one cycle, set SHALL win.
REQ-031 irq_o SHALL be registered: irq_o = |(EVT & IRQ_EN) evaluated on the previous cycle's register values.
REQ-032 Deassertion of cyc or stb after acceptance SHALL NOT cancel the pending ack or the write; the write commits at the accept edge.

Reset
REQ-033 While wb_rst_i=1 at a clock edge, the block SHALL reset: wbs_ack_o=0, wbs_dat_o=0, irq_o=0, CYCLE=0, EVT=0, IRQ_EN=0, scratch=0.
REQ-034 Any transaction accepted in the reset cycle SHALL be discarded, and SHALL NOT be acked.
REQ-035 evt_i SHALL be ignored during reset.
REQ-036 CYCLE SHALL read 1 in the first cycle after reset release.

Verification
REQ-037 Read word 0 at BASE_ADR -> ack 1 cycle later, wbs_dat_o=32'hDB60_0002, then dat=0 and ack=0.
REQ-038 Write 32'hAABBCCDD with sel=4'b0101 to scratch 0 (offset 0x10), which held 0 -> dbg_reg_o[31:0]=32'h00BB00DD; readback matches.
REQ-039 Pulse evt_i[3] one cycle, set IRQ_EN=8'h08 -> EVT reads 8'h08 and irq_o=1; write 8'h08 to EVT while evt_i[3]=1 -> stays 1; repeat with evt_i=0 -> EVT=0 and irq_o=0 one cycle later.
REQ-040 Write to CYCLE, then read 5 cycles later -> the value equals the cycle distance; force the counter to 32'hFFFF_FFFF -> it wraps to 0.
REQ-041 Address BASE_ADR+2^ADR_W and unmapped index 0x3C -> no ack for the former; ack with data 0 for the latter, and a write there changes nothing.
REQ-042 Assert wb_rst_i in the same cycle as an accepted scratch write -> no ack, register stays 0, and all outputs are 0.
